hs_cdc_afifo_wptr: RTL
======================

Name: hs_cdc_afifo_wptr

Overview:
Write-domain pointer and status manager for the team's asynchronous FIFO.
- Keeps the binary write pointer and the RAM write address.
- Drives a registered Gray write pointer to the read-domain multi-bit synchronizer.
- Takes the read Gray pointer after it has passed through the write-domain multi-bit synchronizer.
- Produces full, almost_full and a fill level, so it sits both directly upstream and directly downstream of the Gray-pointer synchronizers.

Parameters:
ADDR_WIDTH, 4, FIFO RAM address width; depth = 2**ADDR_WIDTH; legal 2-16.
AFULL_THRESH, 12, level at or above which almost_full asserts; legal 1 to 2**ADDR_WIDTH.

Ports:
clk  input  1  write-domain clock; the only clock.
areset  input  1  asynchronous, active-high reset.
wr_req  input  1  push request from the writer.
wr_accept  output  1  combinational: wr_req & ~full; the RAM write enable.
waddr  output  ADDR_WIDTH  RAM write address: the low bits of the binary write pointer.
wptr_gray  output  ADDR_WIDTH+1  registered Gray write pointer, sent to the read domain.
rptr_gray_sync  input  ADDR_WIDTH+1  read Gray pointer, already synchronized into clk.
full  output  1  registered full flag.
almost_full  output  1  registered; asserted when level >= AFULL_THRESH.
wr_level  output  ADDR_WIDTH+1  registered conservative fill level, range 0 to 2**ADDR_WIDTH.

Behaviour:
- Reset (areset=1, takes effect asynchronously):
  - wbin=0, wptr_gray=0, waddr=0, full=0, almost_full=0, wr_level=0.
  - wr_accept=0 while reset is held.
- Next-state values, computed every cycle:
  - wbin_next = wbin + wr_accept, modulo 2**(ADDR_WIDTH+1), so the pointer wraps naturally.
  - wgray_next = wbin_next ^ (wbin_next >> 1).
- On each rising edge of clk: wbin <= wbin_next; wptr_gray <= wgray_next.
  - wptr_gray comes straight from a flop. There is no combinational logic between that flop and the port.
- Gray stepping:
  - wptr_gray changes in at most one bit per edge.
  - wptr_gray changes only on edges where wr_accept=1.
- Full:
  - full <= (wgray_next == {~rptr_gray_sync[A:A-1], rptr_gray_sync[A-2:0]}), where A = ADDR_WIDTH.
  - full asserts on the same edge that accepts the last free slot.
  - full deasserts on the first edge after rptr_gray_sync advances.
- Level:
  - rbin_sync = Gray-to-binary of rptr_gray_sync.
  - wr_level <= (wbin_next - rbin_sync) modulo 2**(A+1).
  - almost_full <= ((wbin_next - rbin_sync) >= AFULL_THRESH).
  - The level is conservative: it can only over-estimate occupancy, by the synchronizer latency.
- Overflow: wr_req while full is ignored. wr_accept=0 and every pointer holds its value. No error flag is raised.
- Simultaneous write and read-pointer advance on the same edge: both the new wbin_next and the current rptr_gray_sync are used. The flags must not glitch to full.
- rptr_gray_sync is assumed to be legal Gray code changing by one step at a time; the read side guarantees this. A multi-step jump is still handled arithmetically correctly.
- Reset mid-operation:
  - All state returns to zero immediately, regardless of any write in flight.
  - The system requires the read side to be reset together with this block; no attempt is made to resynchronize a stale rptr_gray_sync.
- Width rules:
  - All pointer arithmetic is on ADDR_WIDTH+1 bits, unsigned, with wrap-around.
  - The AFULL_THRESH comparison is on ADDR_WIDTH+1 bits.

Decomposition:
- Shared package hs_cdc_pkg holds:
  - functions bin2gray and gray2bin, parameterized by width through a typed argument;
  - constant HS_CDC_PTR_MAX_AW = 16.
- One sub-module, hs_cdc_gray_cnt:
  - a binary/Gray counter with enable;
  - outputs the registered Gray value, the binary value and the next-state values;
  - reused by the planned read-side pointer block.
- The full, level and almost_full logic stays in the top module.

Test Plan (ADDR_WIDTH=4, AFULL_THRESH=12):
1. Assert areset mid-cycle with wr_req=1 -> wptr_gray=5'b00000, waddr=0, full=0, almost_full=0, wr_level=0 before the next edge.
2. 16 back-to-back writes with rptr_gray_sync=0:
   - almost_full rises on the edge of write 12 (wr_level=12);
   - after write 16: wr_level=16, wptr_gray=5'b11000, full=1, wr_accept=0.
3. While full, hold wr_req=1 for 5 cycles -> wr_accept=0, waddr=0, wptr_gray stays 5'b11000.
4. From full, set rptr_gray_sync=5'b00001 -> full=0 and wr_level=15 on the next edge; almost_full stays 1.
5. Wrap test: 40 writes with rptr_gray_sync tracking wptr_gray two cycles late:
   - wptr_gray steps 5'b10000 -> 5'b00000 across the wrap;
   - exactly one bit of wptr_gray changes per accepted write;
   - full never asserts.
6. At level 15, on one edge drive wr_req=1 while rptr_gray_sync advances by one -> wr_level stays 15, full=0, almost_full=1.

Source files
------------

// File: rtl/hs_cdc_pkg.sv
// rtl/hs_cdc_pkg.sv - shared Gray-code helpers for the async FIFO pointer blocks
package hs_cdc_pkg;

    localparam int HS_CDC_PTR_MAX_AW = 16;

    // Widest pointer carried by the helpers; callers zero-extend and truncate.
    typedef logic [HS_CDC_PTR_MAX_AW:0] hs_cdc_ptr_t;

    function automatic hs_cdc_ptr_t bin2gray(input hs_cdc_ptr_t b);
        return b ^ (b >> 1);
    endfunction

    function automatic hs_cdc_ptr_t gray2bin(input hs_cdc_ptr_t g);
        hs_cdc_ptr_t b;
        b = g;
        for (int i = 1; i <= HS_CDC_PTR_MAX_AW; i++) begin
            b = b ^ (g >> i);
        end
        return b;
    endfunction

endpackage

// File: rtl/hs_cdc_gray_cnt.sv
// rtl/hs_cdc_gray_cnt.sv - binary/Gray pointer counter with enable
module hs_cdc_gray_cnt
    import hs_cdc_pkg::*;
#(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    output logic [W-1:0] bin,
    output logic [W-1:0] gray,
    output logic [W-1:0] bin_next,
    output logic [W-1:0] gray_next
);

    localparam int PW = HS_CDC_PTR_MAX_AW + 1;

    assign bin_next  = bin + W'(en);
    assign gray_next = W'(bin2gray(PW'(bin_next)));

    // Gray is its own flop so the crossing sees a glitch-free single-bit step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin  <= '0;
            gray <= '0;
        end else begin
            bin  <= bin_next;
            gray <= gray_next;
        end
    end

endmodule

// File: rtl/hs_cdc_afifo_wptr.sv
// rtl/hs_cdc_afifo_wptr.sv - async FIFO write pointer, full/almost_full and level
module hs_cdc_afifo_wptr
    import hs_cdc_pkg::*;
#(
    parameter int ADDR_WIDTH   = 4,
    parameter int AFULL_THRESH = 12
) (
    input  logic                  clk,
    input  logic                  areset,
    input  logic                  wr_req,
    output logic                  wr_accept,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic [ADDR_WIDTH:0]   wptr_gray,
    input  logic [ADDR_WIDTH:0]   rptr_gray_sync,
    output logic                  full,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   wr_level
);

    localparam int A  = ADDR_WIDTH;
    localparam int W  = ADDR_WIDTH + 1;
    localparam int PW = HS_CDC_PTR_MAX_AW + 1;

    logic [W-1:0] wbin;
    logic [W-1:0] wbin_next;
    logic [W-1:0] wgray_next;
    logic [W-1:0] rbin_sync;
    logic [W-1:0] level_next;
    logic [W-1:0] full_gray;
    logic         unused_wbin_msb;

    assign wr_accept = wr_req & ~full & ~areset;

    hs_cdc_gray_cnt #(.W(W)) u_cnt (
        .clk       (clk),
        .rst       (areset),
        .en        (wr_accept),
        .bin       (wbin),
        .gray      (wptr_gray),
        .bin_next  (wbin_next),
        .gray_next (wgray_next)
    );

    assign waddr           = wbin[A-1:0];
    assign unused_wbin_msb = wbin[A];

    // Full when write is exactly one lap ahead: top two Gray bits inverted.
    assign full_gray  = {~rptr_gray_sync[A:A-1], rptr_gray_sync[A-2:0]};
    assign rbin_sync  = W'(gray2bin(PW'(rptr_gray_sync)));
    assign level_next = wbin_next - rbin_sync;

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            full        <= 1'b0;
            almost_full <= 1'b0;
            wr_level    <= '0;
        end else begin
            full        <= (wgray_next == full_gray);
            almost_full <= (level_next >= W'(AFULL_THRESH));
            wr_level    <= level_next;
        end
    end

endmodule
